regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 63 ++++++
 tb/tb_regfile_mp.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with busy scoreboard.
// The optional REGFILE_MP_BYPASS_EN build adds write-to-read forwarding.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W   = 64;
   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_NUM_RD   = 2;
   localparam int unsigned DEF_ZERO_REG = 31;

   // One extra bit so the count can hold the full register count.
   function automatic int unsigned busy_cnt_w(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/alloc bundle between a register-file client and regfile_mp.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned NUM_RD = DEF_NUM_RD
);
   logic [NUM_RD*ADDR_W-1:0]         rdAddr;
   logic [NUM_RD*DATA_W-1:0]         rdData;
   logic [NUM_RD-1:0]                rdBusy;
   logic                             write;
   logic [ADDR_W-1:0]                wrAddr;
   logic [DATA_W-1:0]                wrData;
   logic                             alloc;
   logic [ADDR_W-1:0]                allocAddr;
   logic [busy_cnt_w(ADDR_W)-1:0]    busyCount;

   modport master (
      output rdAddr, write, wrAddr, wrData, alloc, allocAddr,
      input  rdData, rdBusy, busyCount
   );

   modport slave (
      input  rdAddr, write, wrAddr, wrData, alloc, allocAddr,
      output rdData, rdBusy, busyCount
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: alloc marks a register pending, write retires it.
// Keeps a registered count of pending registers; the zero register is never busy.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic                          alloc,
   input  logic [ADDR_W-1:0]             alloc_addr,
   output logic [(1<<ADDR_W)-1:0]        busy,
   output logic [busy_cnt_w(ADDR_W)-1:0] busy_count
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CW    = busy_cnt_w(ADDR_W);
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

   logic [DEPTH-1:0] busy_nxt;
   logic [CW-1:0]    count_nxt;
   logic             inc;
   logic             dec;

   // A same-cycle alloc overrides the retiring write: the new producer wins.
   always_comb begin
      busy_nxt  = busy;
      count_nxt = busy_count;
      if (write) busy_nxt[wr_addr] = 1'b0;
      if (alloc) busy_nxt[alloc_addr] = 1'b1;
      busy_nxt[ZA] = 1'b0;
      inc = alloc && (alloc_addr != ZA) && !busy[alloc_addr];
      dec = write && (wr_addr != ZA) && busy[wr_addr] &&
            !(alloc && (alloc_addr == wr_addr));
      if (inc && !dec)      count_nxt = busy_count + CW'(1);
      else if (dec && !inc) count_nxt = busy_count - CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_count <= count_nxt;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired zero register and busy scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned NUM_RD   = DEF_NUM_RD,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic          clk,
   input  logic          reset,
   regfile_mp_if.slave   bus
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .write      (bus.write),
      .wr_addr    (bus.wrAddr),
      .alloc      (bus.alloc),
      .alloc_addr (bus.allocAddr),
      .busy       (busy),
      .busy_count (bus.busyCount)
   );

   // Storage; the zero register is never written so it stays at its reset value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < int'(DEPTH); j++) mem[j] <= '0;
      end else if (bus.write && (bus.wrAddr != ZA)) begin
         mem[bus.wrAddr] <= bus.wrData;
      end
   end

   for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              is_zero;
      assign ra      = bus.rdAddr[i*ADDR_W +: ADDR_W];
      assign is_zero = (ra == ZA);
`ifdef REGFILE_MP_BYPASS_EN
      // Forwarding is gated by reset so outputs stay zero while it is held.
      logic fwd;
      assign fwd = reset && bus.write && (bus.wrAddr == ra) && !is_zero;
      assign bus.rdData[i*DATA_W +: DATA_W] =
         fwd ? bus.wrData : (is_zero ? '0 : mem[ra]);
      assign bus.rdBusy[i] =
         fwd ? (bus.alloc && (bus.allocAddr == ra)) : (busy[ra] && !is_zero);
`else
      assign bus.rdData[i*DATA_W +: DATA_W] = is_zero ? '0 : mem[ra];
      assign bus.rdBusy[i] = busy[ra] && !is_zero;
`endif
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against a behavioural model; follows REGFILE_MP_BYPASS_EN if defined.
module tb_regfile_mp;
   localparam int unsigned DW = 64;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 2;
   localparam int unsigned ZR = 31;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   logic [DW-1:0] m_mem  [32];
   logic          m_busy [32];

   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_count();
      int n = 0;
      for (int j = 0; j < 32; j++) if (m_busy[j]) n++;
      return n;
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      if (a == AW'(ZR)) return '0;
`ifdef REGFILE_MP_BYPASS_EN
      if (bus.write && bus.wrAddr == a) return bus.wrData;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (a == AW'(ZR)) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
      if (bus.write && bus.wrAddr == a) return bus.alloc && bus.allocAddr == a;
`endif
      return m_busy[a];
   endfunction

   task automatic model_clear();
      for (int j = 0; j < 32; j++) begin
         m_mem[j]  = '0;
         m_busy[j] = 1'b0;
      end
   endtask

   task automatic drive(input logic wr, input int wa, input logic [DW-1:0] wd,
                        input logic al, input int aa, input int r0, input int r1);
      bus.write     = wr;
      bus.wrAddr    = AW'(wa);
      bus.wrData    = wd;
      bus.alloc     = al;
      bus.allocAddr = AW'(aa);
      bus.rdAddr    = {AW'(r1), AW'(r0)};
   endtask

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         if (bus.write && bus.wrAddr != AW'(ZR)) begin
            m_mem[bus.wrAddr]  = bus.wrData;
            m_busy[bus.wrAddr] = 1'b0;
         end
         if (bus.alloc && bus.allocAddr != AW'(ZR)) m_busy[bus.allocAddr] = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_clear();
      drive(1'b1, 1, 64'hDEAD_BEEF_0000_0001, 1'b1, 2, 1, 2);
      #2;
      checks++;
      if (bus.rdData !== '0 || bus.rdBusy !== '0 || bus.busyCount !== '0) begin
         errors++;
         $display("FAIL reset_hold data=%h busy=%b cnt=%0d required 0", bus.rdData, bus.rdBusy, bus.busyCount);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rdData !== '0 || bus.rdBusy !== '0 || bus.busyCount !== '0) begin
         errors++;
         $display("FAIL reset_edge data=%h busy=%b cnt=%0d required 0", bus.rdData, bus.rdBusy, bus.busyCount);
      end
      drive(1'b0, 0, '0, 1'b0, 0, 0, 0);
      #2 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      drive(1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 5, 6);
      tick();
      drive(1'b1, 1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 0, 5, 6);
      tick();
      drive(1'b0, 0, '0, 1'b0, 0, 0, 1);
      #1;
      checks++;
      if (bus.rdData[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL basic_r0 got=%h required=ffffffffffffffff", bus.rdData[63:0]);
      end
      checks++;
      if (bus.rdData[127:64] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
         errors++;
         $display("FAIL basic_r1 got=%h required=aaaaaaaaaaaaaaaa", bus.rdData[127:64]);
      end
      checks++;
      if (bus.rdBusy !== 2'b00) begin
         errors++;
         $display("FAIL basic_busy got=%b required=00", bus.rdBusy);
      end
   endtask

   task automatic test_zero_reg();
      drive(1'b1, 31, 64'h1234, 1'b0, 0, 31, 31);
      tick();
      drive(1'b0, 0, '0, 1'b1, 31, 31, 0);
      #1;
      checks++;
      if (bus.rdData[63:0] !== '0) begin
         errors++;
         $display("FAIL zero_read got=%h required=0", bus.rdData[63:0]);
      end
      tick();
      drive(1'b0, 0, '0, 1'b0, 0, 31, 0);
      #1;
      checks++;
      if (bus.busyCount !== 6'd0 || bus.rdBusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL zero_alloc cnt=%0d busy=%b required cnt=0 busy=0", bus.busyCount, bus.rdBusy[0]);
      end
   endtask

   task automatic test_alloc();
      int exp_cnt [3] = '{1, 2, 2};
      int seq [3]     = '{3, 5, 3};
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 0, '0, 1'b1, seq[k], 3, 5);
         tick();
         checks++;
         if (int'(bus.busyCount) != exp_cnt[k]) begin
            errors++;
            $display("FAIL alloc_cnt%0d got=%0d required=%0d", k, bus.busyCount, exp_cnt[k]);
         end
      end
      drive(1'b1, 3, 64'h33, 1'b0, 0, 3, 5);
      tick();
      drive(1'b0, 0, '0, 1'b0, 0, 3, 5);
      #1;
      checks++;
      if (bus.busyCount !== 6'd1 || bus.rdBusy !== 2'b10 || bus.rdData[63:0] !== 64'h33) begin
         errors++;
         $display("FAIL alloc_retire cnt=%0d busy=%b data=%h required cnt=1 busy=10 data=33",
                  bus.busyCount, bus.rdBusy, bus.rdData[63:0]);
      end
   endtask

   task automatic test_same_cycle();
      drive(1'b1, 7, 64'hCCCC, 1'b1, 7, 7, 5);
      tick();
      drive(1'b0, 0, '0, 1'b0, 0, 7, 5);
      #1;
      checks++;
      if (bus.rdData[63:0] !== 64'hCCCC || bus.rdBusy !== 2'b11 || bus.busyCount !== 6'd2) begin
         errors++;
         $display("FAIL same_cycle data=%h busy=%b cnt=%0d required data=cccc busy=11 cnt=2",
                  bus.rdData[63:0], bus.rdBusy, bus.busyCount);
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] want;
      drive(1'b1, 2, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 0, 2, 0);
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      want = 64'hF0F0_F0F0_F0F0_F0F0;
`else
      want = '0;
`endif
      checks++;
      if (bus.rdData[63:0] !== want) begin
         errors++;
         $display("FAIL bypass_same got=%h required=%h", bus.rdData[63:0], want);
      end
      tick();
      drive(1'b0, 0, '0, 1'b0, 0, 2, 0);
      #1;
      checks++;
      if (bus.rdData[63:0] !== 64'hF0F0_F0F0_F0F0_F0F0) begin
         errors++;
         $display("FAIL bypass_next got=%h required=f0f0f0f0f0f0f0f0", bus.rdData[63:0]);
      end
   endtask

   task automatic test_reset_mid();
      for (int r = 1; r <= 30; r++) begin
         drive(1'b0, 0, '0, 1'b1, r, 1, 2);
         tick();
      end
      checks++;
      if (int'(bus.busyCount) != m_count() || bus.busyCount !== 6'd30) begin
         errors++;
         $display("FAIL fill_cnt got=%0d required=30", bus.busyCount);
      end
      drive(1'b1, 1, 64'h5555, 1'b1, 4, 1, 2);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (bus.busyCount !== '0 || bus.rdData !== '0 || bus.rdBusy !== '0) begin
         errors++;
         $display("FAIL reset_mid cnt=%0d data=%h busy=%b required all 0", bus.busyCount, bus.rdData, bus.rdBusy);
      end
      @(posedge clk); #1;
      model_clear();
      drive(1'b0, 0, '0, 1'b0, 0, 1, 4);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busyCount !== '0 || bus.rdData !== '0) begin
         errors++;
         $display("FAIL reset_discard cnt=%0d data=%h required 0", bus.busyCount, bus.rdData);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int wa = $urandom_range(0, 31);
         int aa = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
         int r0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
         int r1 = $urandom_range(0, 31);
         drive(1'($urandom), wa, {$urandom, $urandom}, 1'($urandom), aa, r0, r1);
         #1;
         checks++;
         if (bus.rdData[63:0] !== exp_data(AW'(r0)) || bus.rdData[127:64] !== exp_data(AW'(r1))) begin
            errors++;
            $display("FAIL rand_data cyc=%0d got=%h required=%h%h", n, bus.rdData,
                     exp_data(AW'(r1)), exp_data(AW'(r0)));
         end
         checks++;
         if (bus.rdBusy !== {exp_busy(AW'(r1)), exp_busy(AW'(r0))} || int'(bus.busyCount) != m_count()) begin
            errors++;
            $display("FAIL rand_busy cyc=%0d busy=%b cnt=%0d required busy=%b cnt=%0d", n, bus.rdBusy,
                     bus.busyCount, {exp_busy(AW'(r1)), exp_busy(AW'(r0))}, m_count());
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_reg();
      test_alloc();
      test_same_cycle();
      test_bypass();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
